// File: rtl/difftest_commit_ctrl_pkg.sv
// Shared types for the difftest commit sequencer: the commit record that
// travels through the FIFO and the sequencer state encoding.
package npc_difftest_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;

   // One retired instruction as reported by the writeback stage.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            wen;
      logic [4:0]      rd;
      logic [XLEN-1:0] wdata;
      logic            skip;
      logic            ebreak;
   } commit_rec_t;

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      PRESENT,
      HALT
   } seq_state_e;

endpackage

// File: rtl/difftest_commit_ctrl_if.sv
// Commit-side and checker-side handshakes of the difftest sequencer.
// master: the core plus the DPI checker; slave: the sequencer itself.
interface difftest_commit_ctrl_if #(
   parameter int XLEN = npc_difftest_pkg::XLEN,
   parameter int NREG = npc_difftest_pkg::NREG
);
   logic                 cmt_valid;
   logic                 cmt_ready;
   logic [XLEN-1:0]      cmt_pc;
   logic [31:0]          cmt_inst;
   logic                 cmt_wen;
   logic [4:0]           cmt_rd;
   logic [XLEN-1:0]      cmt_wdata;
   logic                 cmt_skip;
   logic                 cmt_ebreak;

   logic                 chk_valid;
   logic                 chk_ready;
   logic [XLEN-1:0]      chk_pc;
   logic [31:0]          chk_inst;
   logic                 chk_skip;
   logic [NREG*XLEN-1:0] chk_regs;
   logic [31:0]          chk_seq;
   logic                 halted;

   modport master (
      output cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_rd, cmt_wdata, cmt_skip, cmt_ebreak,
      input  cmt_ready,
      input  chk_valid, chk_pc, chk_inst, chk_skip, chk_regs, chk_seq, halted,
      output chk_ready
   );

   modport slave (
      input  cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_rd, cmt_wdata, cmt_skip, cmt_ebreak,
      output cmt_ready,
      output chk_valid, chk_pc, chk_inst, chk_skip, chk_regs, chk_seq, halted,
      input  chk_ready
   );
endinterface

// File: rtl/difftest_commit_fifo.sv
// Small circular FIFO of commit records between the core and the sequencer.
// Push and pop in the same cycle are both honoured and leave count unchanged.
module commit_fifo
   import npc_difftest_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  commit_rec_t   din,
   input  logic          pop,
   output commit_rec_t   dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   commit_rec_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_en;
   logic          pop_en;

   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   // Storage write.
   // NOTE: the entry array is not reset; pointers and count alone decide which
   // entries are live, so discarding in-flight records only needs them cleared.
   always_ff @(posedge clock) begin
      if (push_en) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/difftest_commit_ctrl.sv
// Commit sequencer: buffers retired-instruction records, applies each one to
// a shadow GPR file and hands one post-commit snapshot at a time to the
// difftest checker. Latches halt once an ebreak record has been consumed.
module difftest_commit_ctrl
   import npc_difftest_pkg::*;
#(
   parameter int XLEN  = npc_difftest_pkg::XLEN,
   parameter int NREG  = npc_difftest_pkg::NREG,
   parameter int DEPTH = 4
) (
   input logic             clock,
   input logic             reset,
   difftest_commit_ctrl_if.slave bus
);

   localparam int CW = $clog2(DEPTH + 1);

   seq_state_e      state_q;
   seq_state_e      state_d;
   commit_rec_t     rec_in;
   commit_rec_t     fifo_dout;
   commit_rec_t     hold_q;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            ebreak_seen_q;
   logic [XLEN-1:0] shadow_q [NREG];
   logic [31:0]     chk_seq_q;

   assign rec_in = '{pc:     bus.cmt_pc,
                     inst:   bus.cmt_inst,
                     wen:    bus.cmt_wen,
                     rd:     bus.cmt_rd,
                     wdata:  bus.cmt_wdata,
                     skip:   bus.cmt_skip,
                     ebreak: bus.cmt_ebreak};

   // Ready comes from registered occupancy only: a same-cycle pop never raises it.
   assign bus.cmt_ready = (fifo_count != CW'(DEPTH)) && !ebreak_seen_q && (state_q != HALT);
   assign push          = bus.cmt_valid && bus.cmt_ready;
   assign pop           = (state_q == IDLE) && !fifo_empty;

   commit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .din   (rec_in),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The full flag must always agree with the count that feeds ready.
   assert property (@(posedge clock) disable iff (reset) fifo_full == (fifo_count == CW'(DEPTH)));

   // Sequencer state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: pop, apply, present, then either idle again or halt on ebreak.
   // NOTE: state_d is defaulted before the case so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty) state_d = APPLY;
         APPLY:   state_d = PRESENT;
         PRESENT: if (bus.chk_ready) state_d = hold_q.ebreak ? HALT : IDLE;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // Hold register: the record currently being applied and presented.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)    hold_q <= '0;
      else if (pop) hold_q <= fifo_dout;
   end

   // Once an ebreak is accepted, no later commit may enter the FIFO.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                        ebreak_seen_q <= 1'b0;
      else if (push && bus.cmt_ebreak)  ebreak_seen_q <= 1'b1;
   end

   // Shadow GPR update and commit counter; x0 is never written so stays zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
         chk_seq_q <= '0;
      end else if (state_q == APPLY) begin
         if (hold_q.wen && (hold_q.rd != 5'd0)) shadow_q[hold_q.rd] <= hold_q.wdata;
         chk_seq_q <= chk_seq_q + 32'd1;
      end
   end

   // Flatten the shadow file for the checker, register i at [i*XLEN +: XLEN].
   always_comb begin
      bus.chk_regs = '0;
      for (int i = 0; i < NREG; i++) bus.chk_regs[i*XLEN +: XLEN] = shadow_q[i];
   end

   assign bus.chk_valid = (state_q == PRESENT);
   assign bus.halted    = (state_q == HALT);
   assign bus.chk_pc    = hold_q.pc;
   assign bus.chk_inst  = hold_q.inst;
   assign bus.chk_skip  = hold_q.skip;
   assign bus.chk_seq   = chk_seq_q;

endmodule

// File: tb/tb_difftest_commit_ctrl.sv
// Self-checking bench for difftest_commit_ctrl: directed table, hand-written
// corner sequences and random traffic, all scored against an ordered list of
// expected snapshots built from the commit stream.
module tb_difftest_commit_ctrl;
   import npc_difftest_pkg::*;

   localparam int DEPTH = 4;
   localparam int W     = NREG * XLEN;
   typedef logic [W-1:0] wide_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   difftest_commit_ctrl_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

   difftest_commit_ctrl #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Expected snapshot for one accepted commit.
   typedef struct {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            skip;
      wide_t           regs;
      logic [31:0]     seq;
      logic            ebreak;
   } snap_t;

   // Directed vector: one commit and what its snapshot must show.
   typedef struct {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            wen;
      logic [4:0]      rd;
      logic [XLEN-1:0] wdata;
      logic            skip;
      int              exp_idx;
      logic [XLEN-1:0] exp_val;
      logic [31:0]     exp_seq;
   } vec_t;

   snap_t           exp_q[$];
   logic [XLEN-1:0] m_regs [NREG];
   logic [31:0]     m_seq;
   logic            m_closed;
   logic            m_halted;
   int              n_vec = 0;
   int              n_err = 0;
   int              n_acc;
   vec_t            tbl [6];

   task automatic check(input string name, input wide_t act, input wide_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_seq    = '0;
      m_closed = 1'b0;
      m_halted = 1'b0;
   endtask

   // Reference: each accepted commit yields the next snapshot in order.
   task automatic model_accept();
      snap_t s;
      if (bus.cmt_wen && bus.cmt_rd != 5'd0) m_regs[bus.cmt_rd] = bus.cmt_wdata;
      m_seq = m_seq + 32'd1;
      s.pc   = bus.cmt_pc;
      s.inst = bus.cmt_inst;
      s.skip = bus.cmt_skip;
      for (int i = 0; i < NREG; i++) s.regs[i*XLEN +: XLEN] = m_regs[i];
      s.seq    = m_seq;
      s.ebreak = bus.cmt_ebreak;
      exp_q.push_back(s);
      if (bus.cmt_ebreak) m_closed = 1'b1;
   endtask

   // One clock: score outputs at the negedge, record handshakes, advance.
   task automatic cycle();
      snap_t s;
      logic  halt_next;
      halt_next = m_halted;
      check("halted", wide_t'(bus.halted), wide_t'(m_halted));
      if (m_halted) check("valid_when_halted", wide_t'(bus.chk_valid), '0);
      if (m_closed) check("ready_after_ebreak", wide_t'(bus.cmt_ready), '0);
      if (bus.chk_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", wide_t'(bus.chk_valid), '0);
         end else begin
            s = exp_q[0];
            check("snap_pc",   wide_t'(bus.chk_pc),   wide_t'(s.pc));
            check("snap_inst", wide_t'(bus.chk_inst), wide_t'(s.inst));
            check("snap_skip", wide_t'(bus.chk_skip), wide_t'(s.skip));
            check("snap_regs", bus.chk_regs,          s.regs);
            check("snap_seq",  wide_t'(bus.chk_seq),  wide_t'(s.seq));
            if (bus.chk_ready) begin
               s = exp_q.pop_front();
               if (s.ebreak) halt_next = 1'b1;
            end
         end
      end
      if (bus.cmt_valid && bus.cmt_ready) begin
         model_accept();
         n_acc++;
      end
      m_halted = halt_next;
      @(negedge clock);
   endtask

   task automatic drive(input logic [XLEN-1:0] pc, input logic [31:0] inst, input logic wen,
                        input logic [4:0] rd, input logic [XLEN-1:0] wdata,
                        input logic skip, input logic ebreak);
      bus.cmt_valid  = 1'b1;
      bus.cmt_pc     = pc;
      bus.cmt_inst   = inst;
      bus.cmt_wen    = wen;
      bus.cmt_rd     = rd;
      bus.cmt_wdata  = wdata;
      bus.cmt_skip   = skip;
      bus.cmt_ebreak = ebreak;
   endtask

   // Asynchronous reset, scored both while asserted and just after release.
   task automatic do_reset();
      reset = 1'b1;
      bus.cmt_valid  = 1'b0;
      bus.cmt_ebreak = 1'b0;
      bus.chk_ready  = 1'b0;
      #2;
      check("rst_chk_valid", wide_t'(bus.chk_valid), '0);
      check("rst_chk_seq",   wide_t'(bus.chk_seq),   '0);
      check("rst_halted",    wide_t'(bus.halted),    '0);
      check("rst_chk_regs",  bus.chk_regs,           '0);
      check("rst_chk_pc",    wide_t'(bus.chk_pc),    '0);
      check("rst_chk_inst",  wide_t'(bus.chk_inst),  '0);
      check("rst_chk_skip",  wide_t'(bus.chk_skip),  '0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_clear();
      n_acc = 0;
      @(negedge clock);
      check("rst_cmt_ready", wide_t'(bus.cmt_ready), wide_t'(1));
   endtask

   // Release the checker and run until every expected snapshot is delivered.
   task automatic drain(input int budget);
      bus.chk_ready = 1'b1;
      for (int c = 0; c < budget && exp_q.size() != 0; c++) cycle();
      check("drain_left", wide_t'(exp_q.size()), '0);
      bus.chk_ready = 1'b0;
   endtask

   // Issue one commit into an idle sequencer and wait for its snapshot.
   task automatic single(input logic [XLEN-1:0] pc, input logic [4:0] rd,
                         input logic [XLEN-1:0] wdata, output int lat);
      drive(pc, 32'h0000_0013, 1'b1, rd, wdata, 1'b0, 1'b0);
      cycle();
      bus.cmt_valid = 1'b0;
      lat = 1;
      while (!bus.chk_valid && lat < 10) begin
         cycle();
         lat++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      tbl[0] = '{32'h8000_0000, 32'h0000_0293, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5,  32'hDEAD_BEEF, 32'd1};
      tbl[1] = '{32'h8000_0004, 32'h0000_0013, 1'b1, 5'd0,  32'h0000_1234, 1'b0, 0,  32'h0000_0000, 32'd2};
      tbl[2] = '{32'h8000_0008, 32'h0000_2F83, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 31, 32'hFFFF_FFFF, 32'd3};
      tbl[3] = '{32'h8000_000C, 32'h0000_0063, 1'b0, 5'd7,  32'h0000_0055, 1'b0, 7,  32'h0000_0000, 32'd4};
      tbl[4] = '{32'h8000_0010, 32'h0010_0293, 1'b1, 5'd5,  32'h0000_0001, 1'b0, 5,  32'h0000_0001, 32'd5};
      tbl[5] = '{32'h8000_0014, 32'hA5A0_0093, 1'b1, 5'd1,  32'hA5A5_A5A5, 1'b0, 1,  32'hA5A5_A5A5, 32'd6};

      bus.cmt_pc = '0; bus.cmt_inst = '0; bus.cmt_wen = 1'b0; bus.cmt_rd = '0;
      bus.cmt_wdata = '0; bus.cmt_skip = 1'b0;
      @(negedge clock);
      do_reset();

      // Directed table: one commit at a time from an idle sequencer.
      for (int i = 0; i < 6; i++) begin
         check("tbl_ready", wide_t'(bus.cmt_ready), wide_t'(1));
         drive(tbl[i].pc, tbl[i].inst, tbl[i].wen, tbl[i].rd, tbl[i].wdata, tbl[i].skip, 1'b0);
         cycle();
         bus.cmt_valid = 1'b0;
         lat = 1;
         while (!bus.chk_valid && lat < 10) begin
            cycle();
            lat++;
         end
         check("tbl_latency", wide_t'(lat), wide_t'(3));
         check("tbl_seq", wide_t'(bus.chk_seq), wide_t'(tbl[i].exp_seq));
         check("tbl_reg", wide_t'(bus.chk_regs[tbl[i].exp_idx*XLEN +: XLEN]), wide_t'(tbl[i].exp_val));
         check("tbl_x0",  wide_t'(bus.chk_regs[XLEN-1:0]), '0);
         check("tbl_pc",  wide_t'(bus.chk_pc), wide_t'(tbl[i].pc));
         cycle();
         cycle();
         bus.chk_ready = 1'b1;
         cycle();
         bus.chk_ready = 1'b0;
      end

      // Backpressure: six back-to-back commits while the checker stalls.
      do_reset();
      for (int c = 0; c < 12; c++) begin
         if (n_acc < 6) drive(32'h0000_0100 + 32'(n_acc * 4), 32'h0000_0013, 1'b1,
                              5'(n_acc + 1), $urandom, 1'b0, 1'b0);
         else bus.cmt_valid = 1'b0;
         cycle();
      end
      check("bp_accepted", wide_t'(n_acc), wide_t'(DEPTH + 1));
      check("bp_ready_low", wide_t'(bus.cmt_ready), '0);
      bus.chk_ready = 1'b1;
      for (int c = 0; c < 40 && n_acc < 6; c++) cycle();
      bus.cmt_valid = 1'b0;
      check("bp_all_accepted", wide_t'(n_acc), wide_t'(6));
      drain(60);

      // Ebreak: A, ebreak accepted; C must be refused forever after.
      do_reset();
      drive(32'h0000_0200, 32'h0000_0013, 1'b1, 5'd3, 32'h0000_0AAA, 1'b0, 1'b0);
      cycle();
      drive(32'h0000_0204, 32'h0010_0073, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
      cycle();
      drive(32'h0000_0208, 32'h0000_0013, 1'b1, 5'd4, 32'h0000_0CCC, 1'b0, 1'b0);
      for (int c = 0; c < 6; c++) cycle();
      check("eb_accepted", wide_t'(n_acc), wide_t'(2));
      check("eb_not_halted_yet", wide_t'(bus.halted), '0);
      bus.chk_ready = 1'b1;
      for (int c = 0; c < 14; c++) cycle();
      check("eb_halted",   wide_t'(bus.halted),    wide_t'(1));
      check("eb_valid",    wide_t'(bus.chk_valid), '0);
      check("eb_ready",    wide_t'(bus.cmt_ready), '0);
      check("eb_consumed", wide_t'(exp_q.size()),  '0);
      bus.cmt_valid = 1'b0;

      // Reset while presenting with three records still queued.
      do_reset();
      for (int c = 0; c < 20 && n_acc < 4; c++) begin
         drive(32'h0000_0300 + 32'(n_acc * 4), 32'h0000_0013, 1'b1, 5'(n_acc + 8),
               $urandom, 1'b0, 1'b0);
         cycle();
      end
      bus.cmt_valid = 1'b0;
      check("mp_accepted", wide_t'(n_acc), wide_t'(4));
      check("mp_valid", wide_t'(bus.chk_valid), wide_t'(1));
      do_reset();
      check("mp_no_stale_valid", wide_t'(bus.chk_valid), '0);
      single(32'h0000_0400, 5'd9, 32'h1357_9BDF, lat);
      check("mp_seq_restart", wide_t'(bus.chk_seq), wide_t'(1));
      drain(20);

      // chk_seq wraps from all-ones to zero.
      do_reset();
      force dut.chk_seq_q = 32'hFFFF_FFFF;
      @(negedge clock);
      release dut.chk_seq_q;
      m_seq = 32'hFFFF_FFFF;
      single(32'h0000_0500, 5'd2, 32'h0000_0042, lat);
      check("wrap_seq", wide_t'(bus.chk_seq), '0);
      drain(20);

      // Random traffic with random checker backpressure.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) != 0)
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom, 1'($urandom_range(0, 1)), 1'b0);
         else bus.cmt_valid = 1'b0;
         bus.chk_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      bus.cmt_valid = 1'b0;
      drain(60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
